// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register, one-word instruction buffer and a FETCH/HOLD/SQUASH
// request FSM that keeps memory requests stable until imem_ready and discards redirected data.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        Branch_Taken,
    input  logic [15:0] Branch_Offset,
    input  logic [31:0] ID_PCplus4,
    input  logic        Jump,
    input  logic [25:0] Jump_Address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] PCplus4,
    output logic        Fetch_Valid,
    output logic        IF_Flush
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] squash_addr_q, squash_addr_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        req;
    logic [31:0] addr;

    assign redirect = Jump | Branch_Taken;
    assign pc_plus4 = pc_q + 32'd4;
    // Jump wins when both are asserted.
    assign target   = Jump ? {ID_PCplus4[31:28], Jump_Address, 2'b00}
                           : ID_PCplus4 + {{14{Branch_Offset[15]}}, Branch_Offset, 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        squash_addr_d = squash_addr_q;
        req           = 1'b0;
        addr          = pc_q;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (redirect) begin
                    pc_d = target;
                    // An outstanding request must still complete at its original address.
                    if (!imem_ready) begin
                        squash_addr_d = pc_q;
                        state_d       = SQUASH;
                    end
                end else if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (PCWrite) begin
                    req  = 1'b1;
                    addr = pc_plus4;
                    pc_d = pc_plus4;
                    if (imem_ready) begin
                        instr_d = imem_rdata;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            SQUASH: begin
                req  = 1'b1;
                addr = squash_addr_q;
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h00000000;
            squash_addr_q <= 32'h00000000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            squash_addr_q <= squash_addr_d;
        end
    end

    assign imem_req    = req & ~reset;
    assign imem_addr   = addr;
    assign Fetch_Valid = (state_q == HOLD) & ~reset;
    assign instruction = Fetch_Valid ? instr_q : 32'h00000000;
    assign PCplus4     = reset ? (RESET_PC + 32'd4) : pc_plus4;
    assign IF_Flush    = redirect;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have a single parameter RESET_PC, default 32'h00000000, which is the PC loaded on reset.
REQ-002 clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 PCWrite  in  1  hazard-unit advance enable; 0 stalls the fetch and holds the presented instruction.
REQ-005 Branch_Taken  in  1  redirect to the branch target.
REQ-006 Branch_Offset  in  16  branch immediate from decode.
REQ-007 ID_PCplus4  in  32  PC+4 of the branch or jump instruction in decode.
REQ-008 Jump  in  1  redirect to the jump target.
REQ-009 Jump_Address  in  26  jump target field from decode.
REQ-010 imem_req  out  1  instruction memory read request.
REQ-011 imem_addr  out  32  instruction memory read address.
REQ-012 imem_ready  in  1  read data valid; completes the current request.
REQ-013 imem_rdata  in  32  instruction memory read data.
REQ-014 instruction  out  32  fetched word to IF/ID; 32'h00000000 (NOP) when Fetch_Valid=0.
REQ-015 PCplus4  out  32  PC+4 of the presented instruction, to IF/ID.
REQ-016 Fetch_Valid  out  1  instruction holds a real fetched word.
REQ-017 IF_Flush  out  1  combinational; equals Branch_Taken|Jump.

Function
REQ-018 The block SHALL contain a PC register, an instruction register, a squash-address register and the FSM states FETCH, HOLD and SQUASH.
REQ-019 Redirect SHALL be Jump|Branch_Taken; Jump has priority.
REQ-020 Jump target SHALL be {ID_PCplus4[31:28], Jump_Address, 2'b00}.
REQ-021 Branch target SHALL be ID_PCplus4 + {{14{Branch_Offset[15]}}, Branch_Offset, 2'b00}, computed mod 2^32.
REQ-022 PCplus4 SHALL be PC+4 mod 2^32; 32'hFFFFFFFC SHALL wrap to 0.
REQ-023 FETCH: imem_req=1, imem_addr=PC; on imem_ready without redirect, capture imem_rdata and go to HOLD with PC unchanged.
REQ-024 FETCH with redirect: PC<=target; on imem_ready, drop the data and stay in FETCH; without imem_ready, save the old address and go to SQUASH.
REQ-025 HOLD: Fetch_Valid=1; with PCWrite=0 and no redirect, hold all state with imem_req=0.
REQ-026 HOLD with PCWrite=1 and no redirect: imem_req=1, imem_addr=PC+4, PC<=PC+4; on imem_ready capture the word and stay in HOLD (1 instruction/cycle); otherwise go to FETCH.
REQ-027 HOLD with redirect, regardless of PCWrite: imem_req=0, PC<=target, go to FETCH.
REQ-028 SQUASH: imem_req=1, imem_addr=squash address; on imem_ready discard the data and go to FETCH.
REQ-029 A further redirect in SQUASH SHALL update PC only.
REQ-030 imem_addr SHALL remain stable while imem_req=1 until imem_ready.
REQ-031 imem_ready SHALL be ignored when imem_req=0.
REQ-032 Redirect SHALL override PCWrite=0 in every state.

Reset
REQ-033 While reset=1: PC=RESET_PC, state=FETCH, instruction register=0, imem_req=0, Fetch_Valid=0, instruction=0, PCplus4=RESET_PC+4.
REQ-034 Reset mid-request SHALL abandon the request without waiting for imem_ready.
REQ-035 The first request SHALL issue in the cycle after reset deasserts.

Verification
REQ-036 Reset; ready=1 always; PCWrite=1; mem[n]=n -> imem_addr 0,4,8,12 on consecutive cycles; instruction 0,4,8 from the 2nd cycle on; PCplus4 4,8,12.
REQ-037 In HOLD with PC=8, PCWrite=0 for 3 cycles -> instruction and PCplus4=12 stable, imem_req=0; on release, imem_addr=12.
REQ-038 Branch_Taken, ID_PCplus4=0x100, Offset=0xFFFE, in HOLD -> IF_Flush=1, Fetch_Valid=0 next cycle, next imem_addr=0x0F8.
REQ-039 Jump, ID_PCplus4=0xA0000004, Jump_Address=0x40, while FETCH is pending with ready=0 -> SQUASH keeps the old imem_addr; late data is discarded; next imem_addr=0xA0000100.
REQ-040 PC=0xFFFFFFFC held -> PCplus4=0; advance -> imem_addr=0.
REQ-041 reset asserted during a pending fetch at PC=0x40 -> next cycle imem_req=0, Fetch_Valid=0; after release, imem_addr=RESET_PC.
